// File: rtl/mem_access_if.sv
// Data-bus interface between the memory stage and the data memory.
// Single outstanding request: req/gnt address phase, rvalid data phase.
interface mem_access_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  bus_req;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [3:0]            bus_be;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_be,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_be,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );

endinterface

// File: rtl/mem_access.sv
// Memory stage: turns EX/MEM loads/stores into data-bus requests,
// stalls while an access is in flight, and extends load results.
module mem_access #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  flush,
  output logic                  stall,
  mem_access_if.master          bus,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;

  logic access;
  logic f_byte;
  logic f_half;
  logic f_word;
  logic aligned;
  logic accept;
  logic reject;

  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;

  logic [1:0] ld_off;
  logic       ld_byte;
  logic       ld_half;
  logic       ld_uns;

  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] ld_ext;

  logic gnt;
  logic rvalid;
  logic take_load;

  assign gnt    = bus.bus_gnt;
  assign rvalid = bus.bus_rvalid;

  // Width decode; reserved encodings fall through to word.
  assign access = in_valid & (mem_read | mem_write);
  assign f_byte = (funct3[1:0] == 2'b00);
  assign f_half = (funct3[1:0] == 2'b01);
  assign f_word = ~f_byte & ~f_half;

  assign aligned = f_byte
                 | (f_half & ~addr[0])
                 | (f_word & (addr[1:0] == 2'b00));

  assign accept = (state == IDLE) & access
                & ~flush & aligned;
  assign reject = (state == IDLE) & access
                & ~flush & ~aligned;

  // Store lane replication and byte enables.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    unique case (1'b1)
      f_byte: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      f_half: begin
        st_be    = 4'b0011 << addr[1:0];
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Next state and pipeline stall.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = REQ;
          stall    = 1'b1;
        end
      end
      REQ: begin
        if (flush) begin
          if (!gnt) begin
            state_nx = IDLE;
          end else if (bus.bus_we) begin
            state_nx = IDLE;
          end else begin
            state_nx = DRAIN;
          end
        end else if (gnt) begin
          if (bus.bus_we) begin
            state_nx = IDLE;
          end else begin
            state_nx = WAIT;
            stall    = 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_nx = rvalid ? IDLE : DRAIN;
        end else if (rvalid) begin
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        stall = 1'b1;
        if (rvalid) begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  assign take_load = (state == WAIT) & rvalid & ~flush;

  // Pick the addressed byte/half and extend it.
  assign rd_sh = bus.bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = bus.bus_rdata;
    unique case (1'b1)
      ld_byte: ld_ext = {{24{~ld_uns & rd_sh[7]}},
                         rd_sh[7:0]};
      ld_half: ld_ext = {{16{~ld_uns & rd_sh[15]}},
                         rd_sh[15:0]};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Bus request; the address phase is frozen until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= 4'b0000;
    end else begin
      bus.bus_req <= (state_nx == REQ);
      if (accept) begin
        bus.bus_we    <= ~mem_read;
        bus.bus_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
        bus.bus_wdata <= mem_read ? '0 : st_wdata;
        bus.bus_be    <= st_be;
      end
    end
  end

  // Load shape captured at accept for use when data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_off  <= 2'b00;
      ld_byte <= 1'b0;
      ld_half <= 1'b0;
      ld_uns  <= 1'b0;
    end else if (accept) begin
      ld_off  <= addr[1:0];
      ld_byte <= f_byte;
      ld_half <= f_half;
      ld_uns  <= funct3[2];
    end
  end

  // Result pulses: load data return and misalignment reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid <= 1'b0;
      load_data  <= '0;
      misaligned <= 1'b0;
    end else begin
      load_valid <= take_load;
      misaligned <= reject;
      if (take_load) begin
        load_data <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment,
// flush and reset-in-flight cases with hand-computed values.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned;

  int checks;
  int failures;

  mem_access_if #(.DATA_WIDTH(32)) bus ();

  mem_access #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .flush      (flush),
    .stall      (stall),
    .bus        (bus),
    .load_valid (load_valid),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    flush     = 1'b0;
  endtask

  // Load with grant and rvalid at the earliest cycles.
  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] rd,
                         input logic [3:0] be,
                         input logic [31:0] exp);
    in_valid = 1'b1;
    mem_read = 1'b1;
    funct3   = f3;
    addr     = a;
    @(negedge clk);
    chk({tag, "_stall_acc"}, 32'(stall), 32'd1);
    to_pos;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    chk({tag, "_req"}, 32'(bus.bus_req), 32'd1);
    chk({tag, "_addr"}, bus.bus_addr,
        {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(bus.bus_be), 32'(be));
    to_pos;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = rd;
    @(negedge clk);
    chk({tag, "_stall_rv"}, 32'(stall), 32'd0);
    to_pos;
    bus.bus_rvalid = 1'b0;
    idle_in();
    @(negedge clk);
    chk({tag, "_lvalid"}, 32'(load_valid), 32'd1);
    chk({tag, "_ldata"}, load_data, exp);
    to_pos;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    idle_in();
    funct3         = 3'b010;
    addr           = '0;
    store_data     = '0;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_be", 32'(bus.bus_be), 32'd0);
    chk("rst_lvalid", 32'(load_valid), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    to_pos;
    rst_n = 1'b1;
    to_pos;

    // LW 0x100, immediate gnt, one idle cycle before rvalid
    in_valid = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h100;
    @(negedge clk);
    chk("lw_stall0", 32'(stall), 32'd1);
    chk("lw_req0", 32'(bus.bus_req), 32'd0);
    to_pos;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    chk("lw_req1", 32'(bus.bus_req), 32'd1);
    chk("lw_addr", bus.bus_addr, 32'h100);
    chk("lw_be", 32'(bus.bus_be), 32'hf);
    chk("lw_we", 32'(bus.bus_we), 32'd0);
    chk("lw_stall1", 32'(stall), 32'd1);
    to_pos;
    bus.bus_gnt = 1'b0;
    @(negedge clk);
    chk("lw_req2", 32'(bus.bus_req), 32'd0);
    chk("lw_stall2", 32'(stall), 32'd1);
    to_pos;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    chk("lw_stall3", 32'(stall), 32'd0);
    chk("lw_lv3", 32'(load_valid), 32'd0);
    to_pos;
    bus.bus_rvalid = 1'b0;
    idle_in();
    @(negedge clk);
    chk("lw_lv4", 32'(load_valid), 32'd1);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_mis4", 32'(misaligned), 32'd0);
    to_pos;
    @(negedge clk);
    chk("lw_lv5", 32'(load_valid), 32'd0);
    to_pos;

    // Sub-word loads at minimum latency
    do_load("lb", 3'b000, 32'h203, 32'h80112233,
            4'b1000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80112233,
            4'b1000, 32'h00000080);
    do_load("lhu", 3'b101, 32'h202, 32'h80112233,
            4'b1100, 32'h00008011);
    do_load("lh", 3'b001, 32'h202, 32'h80112233,
            4'b1100, 32'hFFFF8011);
    do_load("lb0", 3'b000, 32'h200, 32'h80112233,
            4'b0001, 32'h00000033);

    // SB 0x1001, gnt after 3 wait cycles
    in_valid   = 1'b1;
    mem_write  = 1'b1;
    funct3     = 3'b000;
    addr       = 32'h1001;
    store_data = 32'h000000A5;
    @(negedge clk);
    chk("sb_stall0", 32'(stall), 32'd1);
    to_pos;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sb_req_hold", 32'(bus.bus_req), 32'd1);
      chk("sb_stall_hold", 32'(stall), 32'd1);
      chk("sb_wdata", bus.bus_wdata, 32'hA5A5A5A5);
      chk("sb_be", 32'(bus.bus_be), 32'b0010);
      chk("sb_we", 32'(bus.bus_we), 32'd1);
      to_pos;
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    chk("sb_req_gnt", 32'(bus.bus_req), 32'd1);
    chk("sb_stall_gnt", 32'(stall), 32'd0);
    to_pos;
    bus.bus_gnt = 1'b0;
    idle_in();
    @(negedge clk);
    chk("sb_req_done", 32'(bus.bus_req), 32'd0);
    chk("sb_stall_done", 32'(stall), 32'd0);
    to_pos;

    // SH 0x1002, immediate gnt
    in_valid   = 1'b1;
    mem_write  = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h1002;
    store_data = 32'h1234BEEF;
    to_pos;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    chk("sh_wdata", bus.bus_wdata, 32'hBEEFBEEF);
    chk("sh_be", 32'(bus.bus_be), 32'b1100);
    chk("sh_addr", bus.bus_addr, 32'h1000);
    to_pos;
    bus.bus_gnt = 1'b0;
    idle_in();
    to_pos;

    // Misaligned LW 0x102
    in_valid = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h102;
    @(negedge clk);
    chk("mlw_stall", 32'(stall), 32'd0);
    to_pos;
    idle_in();
    @(negedge clk);
    chk("mlw_mis", 32'(misaligned), 32'd1);
    chk("mlw_req", 32'(bus.bus_req), 32'd0);
    chk("mlw_lv", 32'(load_valid), 32'd0);
    to_pos;
    @(negedge clk);
    chk("mlw_mis_end", 32'(misaligned), 32'd0);
    chk("mlw_req_end", 32'(bus.bus_req), 32'd0);
    to_pos;

    // Misaligned SH 0x3
    in_valid   = 1'b1;
    mem_write  = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h3;
    @(negedge clk);
    chk("msh_stall", 32'(stall), 32'd0);
    to_pos;
    idle_in();
    @(negedge clk);
    chk("msh_mis", 32'(misaligned), 32'd1);
    chk("msh_req", 32'(bus.bus_req), 32'd0);
    to_pos;

    // Flush in IDLE blocks acceptance
    in_valid = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h100;
    flush    = 1'b1;
    @(negedge clk);
    chk("fidle_stall", 32'(stall), 32'd0);
    to_pos;
    idle_in();
    @(negedge clk);
    chk("fidle_req", 32'(bus.bus_req), 32'd0);
    to_pos;

    // LW granted, flush in WAIT, rvalid 2 cycles later
    in_valid = 1'b1;
    mem_read = 1'b1;
    addr     = 32'h100;
    to_pos;
    bus.bus_gnt = 1'b1;
    to_pos;
    bus.bus_gnt = 1'b0;
    flush       = 1'b1;
    @(negedge clk);
    chk("fw_stall_flush", 32'(stall), 32'd0);
    to_pos;
    idle_in();
    @(negedge clk);
    chk("fw_stall_drain", 32'(stall), 32'd1);
    to_pos;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h55555555;
    @(negedge clk);
    chk("fw_stall_rv", 32'(stall), 32'd1);
    to_pos;
    bus.bus_rvalid = 1'b0;
    @(negedge clk);
    chk("fw_no_lv", 32'(load_valid), 32'd0);
    chk("fw_stall_idle", 32'(stall), 32'd0);
    to_pos;

    // Flush in REQ before gnt
    in_valid = 1'b1;
    mem_read = 1'b1;
    addr     = 32'h100;
    to_pos;
    flush = 1'b1;
    @(negedge clk);
    chk("fr_req_on", 32'(bus.bus_req), 32'd1);
    chk("fr_stall", 32'(stall), 32'd0);
    to_pos;
    idle_in();
    @(negedge clk);
    chk("fr_req_off", 32'(bus.bus_req), 32'd0);
    to_pos;
    do_load("fr_next", 3'b010, 32'h104, 32'h12345678,
            4'b1111, 32'h12345678);

    // Reset while in WAIT
    in_valid = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h100;
    to_pos;
    bus.bus_gnt = 1'b1;
    to_pos;
    bus.bus_gnt = 1'b0;
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(bus.bus_req), 32'd0);
    chk("rw_addr", bus.bus_addr, 32'd0);
    chk("rw_be", 32'(bus.bus_be), 32'd0);
    chk("rw_ldata", load_data, 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    to_pos;
    rst_n = 1'b1;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'hCAFEF00D;
    to_pos;
    bus.bus_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_late_lv", 32'(load_valid), 32'd0);
    chk("rw_late_stall", 32'(stall), 32'd0);
    to_pos;
    do_load("rw_next", 3'b010, 32'h200, 32'h0BADC0DE,
            4'b1111, 32'h0BADC0DE);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage.
- Takes ALUResult as the byte address, rs2 as store data, and funct3 as the access width/sign.
- Drives a single-outstanding data-bus request with byte enables, waits on grant/response handshakes, and stalls the pipeline while an access is in flight.
- Returns the aligned, sign/zero-extended load value and flags misaligned accesses.

Parameters:
- DATA_WIDTH, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- mem_read  in  1  load instruction.
- mem_write  in  1  store instruction.
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  DATA_WIDTH  byte address (ALUResult).
- store_data  in  DATA_WIDTH  rs2 value.
- flush  in  1  kill the current or in-flight access.
- stall  out  1  hold the upstream pipeline registers.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  DATA_WIDTH  word-aligned address, addr[1:0] = 00.
- bus_wdata  out  DATA_WIDTH  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_WIDTH  read word.
- load_valid  out  1  one-cycle pulse: load_data is valid.
- load_data  out  DATA_WIDTH  extended load result.
- misaligned  out  1  one-cycle pulse: access rejected.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_valid, load_data and misaligned all = 0.
  - Any in-flight access is abandoned.
- access = in_valid & (mem_read | mem_write). mem_read takes priority if both are set.
- Alignment:
  - H/HU requires addr[0] = 0.
  - W requires addr[1:0] = 00.
  - B is always aligned.
- funct3 011, 110 and 111 are treated as W.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - access & !flush & aligned: latch the request and go to REQ. bus_req = 1 from the next cycle. stall = 1 this cycle.
  - access & !flush & misaligned: misaligned = 1 next cycle, no bus activity, stall = 0.
- REQ:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_be are held stable until bus_gnt.
  - gnt on a write: go to IDLE. stall = 0 in the gnt cycle; the store completes.
  - gnt on a read: go to WAIT. stall = 1.
  - bus_req drops in the cycle after gnt.
- WAIT:
  - stall = 1 until bus_rvalid.
  - On rvalid: go to IDLE, stall = 0 that cycle, load_valid = 1 and load_data registered on the next cycle.
  - bus_rvalid in the same cycle as bus_gnt is never expected; rvalid arrives at least 1 cycle after gnt.
- DRAIN: stall = 1. Stays until bus_rvalid, discards the data, then goes to IDLE with no load_valid.
- Flush:
  - IDLE: blocks acceptance.
  - REQ without gnt: drop bus_req next cycle, go to IDLE.
  - REQ with gnt on a read: go to DRAIN.
  - REQ with gnt on a write: the store completes.
  - WAIT: go to DRAIN. If bus_rvalid is in the same cycle, go to IDLE instead; data is discarded either way.
  - stall = 0 in every flush cycle except when in DRAIN.
- Store lanes:
  - SB: wdata = 4 copies of the low byte; be = 0001 << addr[1:0].
  - SH: wdata = 2 copies of the low half; be = 0011 << addr[1:0].
  - SW: be = 1111.
- Load extract:
  - Select byte/half by the latched addr[1:0].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- Timing:
  - Minimum load latency is accept + 3 cycles to load_valid, with gnt and rvalid each arriving at the earliest possible cycle.
  - Minimum store occupancy is 2 cycles.
- load_valid and misaligned are never high together.

Test Plan:
- LW addr 0x100, gnt after 0 wait cycles, rvalid 1 cycle later with 0xDEADBEEF -> bus_addr 0x100, be 1111, stall high 3 cycles, load_valid with 0xDEADBEEF.
- LB addr 0x203, rdata 0x80112233 -> load_data 0xFFFFFF80. LBU, same stimulus -> 0x00000080. LHU addr 0x202 -> 0x00008011.
- SB addr 0x1001, store_data 0x000000A5, gnt delayed 3 cycles -> wdata 0xA5A5A5A5, be 0010, req held 4 cycles, stall 0 in the gnt cycle.
- LW addr 0x102 -> misaligned pulse, bus_req never asserted, stall 0. SH addr 0x3 -> misaligned.
- LW granted, flush in WAIT, rvalid 2 cycles later -> DRAIN, no load_valid, stall high until rvalid. Flush in REQ before gnt -> bus_req drops next cycle, state IDLE.
- rst_n asserted in WAIT -> all outputs 0 immediately. A later rvalid is ignored; the next LW proceeds normally.
